// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// One transaction in flight: IDLE (grant) -> ACCESS -> RESP (reads only).
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                rd_done0_q, rd_done0_d, rd_done1_q, rd_done1_d;
  logic                grant, pick;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rd_done0_q <= 1'b0;
      rd_done1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      port_q     <= port_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rd_done0_q <= rd_done0_d;
      rd_done1_q <= rd_done1_d;
    end
  end

  // Tie goes to the port not served last; a lone request always wins.
  always_comb begin
    grant      = 1'b0;
    pick       = 1'b0;
    state_d    = state_q;
    last_d     = last_q;
    port_d     = port_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    rd_done0_d = 1'b0;
    rd_done1_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!RST && (req0 || req1)) begin
          grant   = 1'b1;
          pick    = (req0 && req1) ? ~last_q : req1;
          last_d  = pick;
          port_d  = pick;
          we_d    = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = we_q ? IDLE : RESP;
      RESP: begin
        if (port_q) begin
          rdata1_d   = read_data;
          rd_done1_d = 1'b1;
        end else begin
          rdata0_d   = read_data;
          rd_done0_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write completion is combinational in ACCESS; read completion is registered.
  logic wr_done;
  assign wr_done    = (state_q == ACCESS) && we_q && !RST;
  assign gnt0       = grant && !pick;
  assign gnt1       = grant && pick;
  assign done0      = (wr_done && !port_q) || rd_done0_q;
  assign done1      = (wr_done && port_q) || rd_done1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign busy       = (state_q != IDLE);
  assign MemWrite   = (state_q == ACCESS) && we_q;
  assign MemRead    = (state_q == ACCESS) && !we_q;
  assign address    = (state_q == ACCESS) ? addr_q : '0;
  assign write_data = (state_q == ACCESS) ? wdata_q : '0;
  assign dbg_state  = state_q;

endmodule
